// File: rtl/hub75_scan_pkg.sv
// hub75_scan_pkg: shared state enum, pixel fields and sizing helpers
// for the HUB75 framebuffer scan-out engine.
package hub75_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_T,
    FETCH_B,
    LOAD,
    SHIFT,
    CLOCK,
    LATCH,
    DISPLAY
  } state_t;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  function automatic int clog2_min1(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int col_w(int pw);
    return clog2_min1(pw);
  endfunction

  function automatic int row_w(int rows);
    return clog2_min1(rows);
  endfunction

  function automatic int plane_w(int bits);
    return clog2_min1(bits);
  endfunction

  function automatic int disp_w(int base, int bits);
    return $clog2(base) + bits;
  endfunction

  // Bottom half rows live SCAN_ROWS rows further into the buffer.
  function automatic int pix_addr(
    int row, int col, logic bot, int rows, int width
  );
    return (row + (bot ? rows : 0)) * width + col;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: BCM display window down-counter with lit-window compare.
// HUB75_BRIGHTNESS_EN adds a global brightness scale sampled at start.
module hub75_bcm_timer
  import hub75_scan_pkg::*;
#(
  parameter int BASE_CYCLES = 4,
  parameter int BCM_BITS    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         run,
  input  logic [plane_w(BCM_BITS)-1:0] plane,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]                   brightness,
`endif
  output logic                         done,
  output logic                         lit_nxt
);

  localparam int DW = disp_w(BASE_CYCLES, BCM_BITS);

  logic [DW-1:0] disp, disp_n;
  logic [DW-1:0] thr, thr_n;
  logic [DW-1:0] win;
  logic [DW-1:0] on_len;

  assign win = DW'(BASE_CYCLES) << plane;

`ifdef HUB75_BRIGHTNESS_EN
  logic [DW+7:0] prod;
  assign prod   = {8'd0, win} * {{DW{1'b0}}, brightness};
  assign on_len = DW'(prod >> 8);
`else
  assign on_len = win;
`endif

  // Lit while the remaining count is above thr: first on_len cycles.
  always_comb begin
    disp_n = disp;
    thr_n  = thr;
    if (start) begin
      disp_n = win;
      thr_n  = win - on_len;
    end else if (run && disp != '0) begin
      disp_n = disp - 1'b1;
    end
  end

  assign done    = run && (disp == DW'(1));
  assign lit_nxt = disp_n > thr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= '0;
      thr  <= '0;
    end else begin
      disp <= disp_n;
      thr  <= thr_n;
    end
  end

endmodule

// File: rtl/hub75_scan.sv
// hub75_scan: framebuffer read, HUB75 shift/latch/OE sequencing with BCM.
// Optional HUB75_BRIGHTNESS_EN adds an 8-bit brightness input.
module hub75_scan
  import hub75_scan_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PANEL_WIDTH = 64,
  parameter int SCAN_ROWS   = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int BCM_BITS    = 8,
  parameter int BASE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  output logic                          ram_re,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  input  logic [DATA_WIDTH-1:0]         ram_dout,
  output logic                          r0,
  output logic                          g0,
  output logic                          b0,
  output logic                          r1,
  output logic                          g1,
  output logic                          b1,
  output logic                          sclk,
  output logic                          latch,
  output logic                          oe_n,
  output logic [row_w(SCAN_ROWS)-1:0]   row_addr,
  output logic                          frame_start
`ifdef HUB75_BRIGHTNESS_EN
  ,
  input  logic [7:0]                    brightness
`endif
);

  localparam int COL_W = col_w(PANEL_WIDTH);
  localparam int ROW_W = row_w(SCAN_ROWS);
  localparam int PLN_W = plane_w(BCM_BITS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PANEL_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SCAN_ROWS - 1);
  localparam logic [PLN_W-1:0] PLN_LAST = PLN_W'(BCM_BITS - 1);

  state_t state, nstate;
  logic [COL_W-1:0] col, col_n;
  logic [ROW_W-1:0] row, row_n;
  logic [PLN_W-1:0] plane, plane_n;
  logic frame_go;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [23:0] top_q;
  logic [2:0] pidx;
  logic tmr_start, tmr_run, tmr_done, tmr_lit;
  logic unused_dout;

  assign unused_dout = ^ram_dout[DATA_WIDTH-1:24];
  assign pidx        = 3'(plane);
  assign tmr_start   = (state == LATCH);
  assign tmr_run     = (state == DISPLAY);

  hub75_bcm_timer #(
    .BASE_CYCLES(BASE_CYCLES),
    .BCM_BITS   (BCM_BITS)
  ) u_tmr (
    .clk       (clk),
    .rst       (rst),
    .start     (tmr_start),
    .run       (tmr_run),
    .plane     (plane),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .done      (tmr_done),
    .lit_nxt   (tmr_lit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      plane <= '0;
    end else begin
      state <= nstate;
      col   <= col_n;
      row   <= row_n;
      plane <= plane_n;
    end
  end

  always_comb begin
    nstate   = state;
    col_n    = col;
    row_n    = row;
    plane_n  = plane;
    frame_go = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          nstate   = FETCH_T;
          col_n    = '0;
          row_n    = '0;
          plane_n  = '0;
          frame_go = 1'b1;
        end
      end
      FETCH_T: nstate = FETCH_B;
      FETCH_B: nstate = LOAD;
      LOAD:    nstate = SHIFT;
      SHIFT:   nstate = CLOCK;
      CLOCK: begin
        if (col == COL_LAST) begin
          nstate = LATCH;
        end else begin
          col_n  = col + 1'b1;
          nstate = FETCH_T;
        end
      end
      LATCH: nstate = DISPLAY;
      DISPLAY: begin
        if (tmr_done) begin
          col_n  = '0;
          nstate = en ? FETCH_T : IDLE;
          if (plane == PLN_LAST) begin
            plane_n = '0;
            if (row == ROW_LAST) begin
              row_n  = '0;
              nstate = IDLE;
            end else begin
              row_n = row + 1'b1;
            end
          end else begin
            plane_n = plane + 1'b1;
          end
        end
      end
      default: nstate = IDLE;
    endcase
    addr_nxt = ADDR_WIDTH'(pix_addr(int'(row_n), int'(col_n),
                                    nstate == FETCH_B,
                                    SCAN_ROWS, PANEL_WIDTH));
  end

  logic [7:0] t_r, t_g, t_b, d_r, d_g, d_b;
  assign t_r = top_q[R_LSB +: 8];
  assign t_g = top_q[G_LSB +: 8];
  assign t_b = top_q[B_LSB +: 8];
  assign d_r = ram_dout[R_LSB +: 8];
  assign d_g = ram_dout[G_LSB +: 8];
  assign d_b = ram_dout[B_LSB +: 8];

  // Outputs are registered from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_re      <= 1'b0;
      ram_addr    <= '0;
      top_q       <= '0;
      {r0, g0, b0, r1, g1, b1} <= '0;
      sclk        <= 1'b0;
      latch       <= 1'b0;
      oe_n        <= 1'b1;
      row_addr    <= '0;
      frame_start <= 1'b0;
    end else begin
      ram_re      <= (nstate == FETCH_T) || (nstate == FETCH_B);
      if ((nstate == FETCH_T) || (nstate == FETCH_B))
        ram_addr <= addr_nxt;
      if (state == FETCH_B)
        top_q <= ram_dout[23:0];
      if (state == LOAD) begin
        r0 <= t_r[pidx];
        g0 <= t_g[pidx];
        b0 <= t_b[pidx];
        r1 <= d_r[pidx];
        g1 <= d_g[pidx];
        b1 <= d_b[pidx];
      end
      sclk        <= (nstate == CLOCK);
      latch       <= (nstate == LATCH);
      if (nstate == LATCH)
        row_addr <= row;
      oe_n        <= !((nstate == DISPLAY) && tmr_lit);
      frame_start <= frame_go;
    end
  end

endmodule
